// File: rtl/display_arbiter.sv
// N-way display source arbiter: debounced cycle button, per-source unlock gating,
// blank frame on every switch, registered outputs to the Matrix/Numbers drivers.
module display_arbiter #(
   parameter int               NUM_SRC      = 4,
   parameter int               MAT_W        = 128,
   parameter int               NUM_W        = 32,
   parameter int               DEBOUNCE_CYC = 100000,
   parameter int               BLANK_CYC    = 50000,
   parameter logic [NUM_W-1:0] NUM_BLANK    = 32'h0000_0000,
   localparam int              IW           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_btn_next,
   input  logic [NUM_SRC-1:0]         i_src_valid,
   input  logic [NUM_SRC*MAT_W-1:0]   i_matrix_in,
   input  logic [NUM_SRC*NUM_W-1:0]   i_numbers_in,
   output logic [MAT_W-1:0]           o_matrix_out,
   output logic [NUM_W-1:0]           o_numbers_out,
   output logic [NUM_SRC-1:0]         o_src_en,
   output logic [IW-1:0]              o_cur_src,
   output logic                       o_switching
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int BW = $clog2(BLANK_CYC + 1);

   typedef enum logic {S_SHOW, S_BLANK} state_t;

   state_t               r_state;
   logic [1:0]           r_sync;
   logic [DW-1:0]        r_db_cnt;
   logic                 r_db_lvl;
   logic                 r_press;
   logic [BW-1:0]        r_blank_cnt;
   logic [IW-1:0]        r_cur;
   logic [MAT_W-1:0]     r_mat;
   logic [NUM_W-1:0]     r_num;
   logic [NUM_SRC-1:0]   r_en;
   logic                 r_sw;

   logic [NUM_SRC-1:0]   w_valid;
   logic [NUM_SRC-1:0]   w_cur_oh;
   logic                 w_cur_valid;
   logic                 w_found;
   logic [IW-1:0]        w_tgt;
   logic [MAT_W-1:0]     w_mat_sel;
   logic [NUM_W-1:0]     w_num_sel;

   assign w_valid     = i_src_valid | {{(NUM_SRC-1){1'b0}}, 1'b1};
   assign w_cur_valid = w_valid[r_cur];
   assign w_cur_oh    = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_cur;
   assign w_mat_sel   = i_matrix_in[r_cur*MAT_W +: MAT_W];
   assign w_num_sel   = i_numbers_in[r_cur*NUM_W +: NUM_W];

   // Round-robin search after r_cur; wrap is explicit so non-power-of-2 counts work.
   always_comb begin
      logic [IW-1:0] w_idx;
      w_found = 1'b0;
      w_tgt   = '0;
      w_idx   = r_cur;
      for (int k = 1; k < NUM_SRC; k++) begin
         if (w_idx == IW'(NUM_SRC - 1)) w_idx = '0;
         else                           w_idx = w_idx + 1'b1;
         if (!w_found && w_valid[w_idx]) begin
            w_found = 1'b1;
            w_tgt   = w_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync   <= '0;
         r_db_cnt <= '0;
         r_db_lvl <= 1'b0;
         r_press  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn_next};
         r_press <= 1'b0;
         if (r_sync[1] == r_db_lvl) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
            r_db_lvl <= ~r_db_lvl;
            r_db_cnt <= '0;
            r_press  <= ~r_db_lvl;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_SHOW;
         r_cur       <= '0;
         r_blank_cnt <= '0;
         r_en        <= NUM_SRC'(1);
         r_sw        <= 1'b0;
         r_mat       <= '0;
         r_num       <= NUM_BLANK;
      end else begin
         case (r_state)
            S_SHOW: begin
               if ((r_cur != '0 && !w_cur_valid) || (r_press && w_found)) begin
                  // Losing the unlock on the shown source beats a press in the same cycle.
                  r_cur       <= (r_cur != '0 && !w_cur_valid) ? '0 : w_tgt;
                  r_state     <= S_BLANK;
                  r_blank_cnt <= '0;
                  r_mat       <= '0;
                  r_num       <= NUM_BLANK;
                  r_en        <= '0;
                  r_sw        <= 1'b1;
               end else begin
                  r_mat <= w_mat_sel;
                  r_num <= w_num_sel;
                  r_en  <= w_cur_oh;
               end
            end
            S_BLANK: begin
               if (r_cur != '0 && !w_cur_valid) begin
                  r_cur       <= '0;
                  r_blank_cnt <= '0;
               end else if (r_blank_cnt == BW'(BLANK_CYC - 1)) begin
                  r_state <= S_SHOW;
                  r_sw    <= 1'b0;
                  r_mat   <= w_mat_sel;
                  r_num   <= w_num_sel;
                  r_en    <= w_cur_oh;
               end else begin
                  r_blank_cnt <= r_blank_cnt + 1'b1;
               end
            end
            default: r_state <= S_SHOW;
         endcase
      end
   end

   assign o_matrix_out  = r_mat;
   assign o_numbers_out = r_num;
   assign o_src_en      = r_en;
   assign o_cur_src     = r_cur;
   assign o_switching   = r_sw;
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: reset, cycling with skip/wrap, glitch rejection,
// presses during blank, invalidation priority and blank restart, reset mid-blank.
module tb_display_arbiter;
   localparam int NS = 4, MW = 128, NW = 32;
   localparam logic [NW-1:0] NB = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst, btn;
   logic [NS-1:0] valid;
   logic [NS*MW-1:0] mat_in;
   logic [NS*NW-1:0] num_in;
   logic [MW-1:0] mat_out, mat_out_l;
   logic [NW-1:0] num_out, num_out_l;
   logic [NS-1:0] en, en_l;
   logic [1:0] cur, cur_l;
   logic sw, sw_l;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   display_arbiter #(.NUM_SRC(NS), .MAT_W(MW), .NUM_W(NW), .DEBOUNCE_CYC(4),
                     .BLANK_CYC(3), .NUM_BLANK(NB)) dut (
      .clk(clk), .rst(rst), .i_btn_next(btn), .i_src_valid(valid),
      .i_matrix_in(mat_in), .i_numbers_in(num_in), .o_matrix_out(mat_out),
      .o_numbers_out(num_out), .o_src_en(en), .o_cur_src(cur), .o_switching(sw));

   display_arbiter #(.NUM_SRC(NS), .MAT_W(MW), .NUM_W(NW), .DEBOUNCE_CYC(4),
                     .BLANK_CYC(16), .NUM_BLANK(NB)) dut_long (
      .clk(clk), .rst(rst), .i_btn_next(btn), .i_src_valid(valid),
      .i_matrix_in(mat_in), .i_numbers_in(num_in), .o_matrix_out(mat_out_l),
      .o_numbers_out(num_out_l), .o_src_en(en_l), .o_cur_src(cur_l), .o_switching(sw_l));

   function automatic logic [MW-1:0] smat(int i);
      return {16{8'(i)}};
   endfunction
   function automatic logic [NW-1:0] snum(int i);
      return {4{8'(i + 8'h10)}};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; btn = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Raw edge, 7 edges later the FSM has acted on the press pulse.
   task automatic press_to_blank();
      btn = 1'b1;
      repeat (7) tick();
      btn = 1'b0;
   endtask

   task automatic settle();
      repeat (13) tick();
   endtask

   task automatic test_reset();
      bit saw_sw;
      valid = 4'b0001;
      rst = 1'b1; btn = 1'b0;
      tick(); tick();
      total++; if (cur !== 2'd0 || en !== 4'b0001 || sw !== 1'b0) begin bad++;
         $display("FAIL reset_ctl cur=%0d en=%b sw=%b want 0 0001 0", cur, en, sw); end
      total++; if (mat_out !== '0 || num_out !== NB) begin bad++;
         $display("FAIL reset_data num=%h want %h mat nonzero=%b", num_out, NB, |mat_out); end
      rst = 1'b0;
      tick();
      total++; if (mat_out !== smat(0) || num_out !== snum(0)) begin bad++;
         $display("FAIL show_src0 num=%h want %h", num_out, snum(0)); end
      saw_sw = 1'b0;
      btn = 1'b1;
      repeat (20) begin tick(); if (sw !== 1'b0 || cur !== 2'd0) saw_sw = 1'b1; end
      btn = 1'b0;
      repeat (10) begin tick(); if (sw !== 1'b0 || cur !== 2'd0) saw_sw = 1'b1; end
      total++; if (saw_sw) begin bad++;
         $display("FAIL no_target_switch saw switch/cur change, want none"); end
      total++; if (en !== 4'b0001 || cur !== 2'd0) begin bad++;
         $display("FAIL no_target_final en=%b cur=%0d want 0001 0", en, cur); end
   endtask

   task automatic test_press();
      valid = 4'b1011;
      btn = 1'b1;
      repeat (6) tick();
      total++; if (sw !== 1'b0) begin bad++;
         $display("FAIL press_latency sw=%b want 0 before pulse acted", sw); end
      tick();
      btn = 1'b0;
      total++; if (sw !== 1'b1 || cur !== 2'd1 || en !== 4'b0000) begin bad++;
         $display("FAIL blank_enter sw=%b cur=%0d en=%b want 1 1 0000", sw, cur, en); end
      total++; if (mat_out !== '0 || num_out !== NB) begin bad++;
         $display("FAIL blank_data num=%h want %h", num_out, NB); end
      tick(); tick();
      total++; if (sw !== 1'b1) begin bad++;
         $display("FAIL blank_len sw=%b want 1 on third blank cycle", sw); end
      tick();
      total++; if (sw !== 1'b0 || en !== 4'b0010 || mat_out !== smat(1) || num_out !== snum(1)) begin bad++;
         $display("FAIL show_src1 sw=%b en=%b num=%h want 0 0010 %h", sw, en, num_out, snum(1)); end
      settle();
   endtask

   task automatic test_cycle_wrap();
      press_to_blank(); settle();
      total++; if (cur !== 2'd3 || en !== 4'b1000 || mat_out !== smat(3)) begin bad++;
         $display("FAIL skip_to_3 cur=%0d en=%b want 3 1000", cur, en); end
      press_to_blank(); settle();
      total++; if (cur !== 2'd0 || en !== 4'b0001 || num_out !== snum(0)) begin bad++;
         $display("FAIL wrap_to_0 cur=%0d en=%b want 0 0001", cur, en); end
   endtask

   task automatic test_glitch();
      bit moved;
      moved = 1'b0;
      btn = 1'b1;
      repeat (3) tick();
      btn = 1'b0;
      repeat (12) begin tick(); if (sw !== 1'b0 || cur !== 2'd0) moved = 1'b1; end
      total++; if (moved) begin bad++;
         $display("FAIL glitch cur=%0d sw=%b want state unchanged", cur, sw); end
   endtask

   task automatic test_press_in_blank();
      valid = 4'b1011;
      do_reset();
      tick();
      press_to_blank();
      total++; if (sw_l !== 1'b1 || cur_l !== 2'd1) begin bad++;
         $display("FAIL long_blank_enter sw=%b cur=%0d want 1 1", sw_l, cur_l); end
      repeat (6) tick();
      btn = 1'b1;
      repeat (8) tick();
      total++; if (sw_l !== 1'b1 || cur_l !== 2'd1) begin bad++;
         $display("FAIL press_in_blank sw=%b cur=%0d want 1 1", sw_l, cur_l); end
      btn = 1'b0;
      repeat (4) tick();
      total++; if (sw_l !== 1'b0 || cur_l !== 2'd1 || en_l !== 4'b0010) begin bad++;
         $display("FAIL blank_press_dropped sw=%b cur=%0d en=%b want 0 1 0010", sw_l, cur_l, en_l); end
      settle();
   endtask

   task automatic test_invalidate();
      valid = 4'b1011;
      do_reset();
      tick();
      press_to_blank(); settle();
      total++; if (cur !== 2'd1) begin bad++;
         $display("FAIL inv_setup cur=%0d want 1", cur); end
      btn = 1'b1;
      repeat (6) tick();
      valid = 4'b1001;
      tick();
      btn = 1'b0;
      total++; if (sw !== 1'b1 || cur !== 2'd0) begin bad++;
         $display("FAIL inv_beats_press sw=%b cur=%0d want 1 0", sw, cur); end
      settle();
      valid = 4'b1011;
      press_to_blank();
      tick();
      valid = 4'b1001;
      tick();
      total++; if (sw !== 1'b1 || cur !== 2'd0) begin bad++;
         $display("FAIL retarget sw=%b cur=%0d want 1 0", sw, cur); end
      tick(); tick();
      total++; if (sw !== 1'b1) begin bad++;
         $display("FAIL blank_restart sw=%b want 1 after 2 more cycles", sw); end
      tick();
      total++; if (sw !== 1'b0 || cur !== 2'd0 || en !== 4'b0001 || mat_out !== smat(0)) begin bad++;
         $display("FAIL retarget_end sw=%b cur=%0d en=%b want 0 0 0001", sw, cur, en); end
      settle();
   endtask

   task automatic test_reset_mid_blank();
      valid = 4'b1011;
      press_to_blank();
      total++; if (sw !== 1'b1) begin bad++;
         $display("FAIL rst_setup sw=%b want 1", sw); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (cur !== 2'd0 || sw !== 1'b0 || en !== 4'b0001 || num_out !== NB || mat_out !== '0) begin bad++;
         $display("FAIL rst_mid_blank cur=%0d sw=%b en=%b num=%h want 0 0 0001 %h", cur, sw, en, num_out, NB); end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         mat_in[i*MW +: MW] = smat(i);
         num_in[i*NW +: NW] = snum(i);
      end
      rst = 1'b1; btn = 1'b0; valid = 4'b0001;
      test_reset();
      test_press();
      test_cycle_wrap();
      test_glitch();
      test_press_in_blank();
      test_invalidate();
      test_reset_mid_blank();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
